op_lut_hdr_word_tracker: RTL and testbench

//  Upstream stage of the output-port-lookup pipeline. It watches the 64-bit NetFPGA-style packet bus.
//  It emits one-cycle word strobes that align with in_data: MAC, IP header and dest-IP words.

---
 rtl/op_lut_hdr_word_tracker_pkg.sv | 27 ++
 rtl/op_lut_stat_counter.sv | 26 ++
 rtl/op_lut_hdr_word_tracker.sv | 150 +++++++++++++++
 tb/tb_op_lut_hdr_word_tracker.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/op_lut_hdr_word_tracker_pkg.sv
// Shared op-LUT definitions: header word indices, ethertype and tracker FSM states.
// Used by the header word tracker and the downstream filter/ARP blocks.
package op_lut_hdr_word_tracker_pkg;

    localparam int unsigned WORD_CNT_W      = 3;
    localparam int unsigned WORD_MAC_DA     = 0;
    localparam int unsigned WORD_MAC_SA_ETH = 1;
    localparam int unsigned WORD_IP_LEN_TTL = 2;
    localparam int unsigned WORD_IP_SRC_DST = 3;
    localparam int unsigned WORD_IP_DST_LO  = 4;
    localparam int unsigned WORD_CNT_SAT    = 5;

    localparam logic [15:0] ETH_TYPE_IP  = 16'h0800;
    localparam logic [3:0]  IP_VERSION_4 = 4'd4;

    typedef enum logic [1:0] {
        MOD_HDRS = 2'd0,
        IN_HDR   = 2'd1,
        PAYLOAD  = 2'd2
    } tracker_state_e;

    // IPv4 test on word 1: ethertype field and IP version nibble.
    function automatic logic is_ipv4(input logic [15:0] ethertype, input logic [3:0] version);
        return (ethertype == ETH_TYPE_IP) && (version == IP_VERSION_4);
    endfunction

endpackage

// File: rtl/op_lut_stat_counter.sv
// Statistics counter: increments by one on each inc_i pulse, wraps modulo 2^CNT_WIDTH.
// Ports: clk, reset (sync, active-high), inc_i (increment pulse), count_o (current count).
module op_lut_stat_counter
    import op_lut_hdr_word_tracker_pkg::*;
#(
    parameter int unsigned CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 inc_i,
    output logic [CNT_WIDTH-1:0] count_o
);

    logic [CNT_WIDTH-1:0] count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else if (inc_i) begin
            count_q <= count_q + CNT_WIDTH'(1);
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/op_lut_hdr_word_tracker.sv
// Output-port-lookup header word tracker. Watches the 64-bit packet bus and emits
// zero-latency strobes aligned with the MAC / IP header words, plus per-packet IPv4
// status, an EOP pulse, a short-packet pulse and packet/short-packet counters.
// Ports:
//   clk, reset (sync, active-high)
//   in_data, in_ctrl, in_wr          observed packet bus (never modified)
//   word_MAC_DA .. word_IP_DST_LO    one-cycle strobes for header words 0..4
//   pkt_is_ipv4                      registered at word 1, cleared after EOP
//   eop, short_pkt                   pulses with the last word of a packet
//   num_pkts, num_short_pkts         wrapping statistics counters
// Configuration: define OP_LUT_IPV4_GATE_EN to gate IP word strobes and short_pkt
// on pkt_is_ipv4.
module op_lut_hdr_word_tracker
    import op_lut_hdr_word_tracker_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned CTRL_WIDTH = DATA_WIDTH / 8,
    parameter int unsigned CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [CTRL_WIDTH-1:0] in_ctrl,
    input  logic                  in_wr,
    output logic                  word_MAC_DA,
    output logic                  word_MAC_SA_ETH,
    output logic                  word_IP_LEN_TTL,
    output logic                  word_IP_SRC_DST,
    output logic                  word_IP_DST_LO,
    output logic                  pkt_is_ipv4,
    output logic                  eop,
    output logic                  short_pkt,
    output logic [CNT_WIDTH-1:0]  num_pkts,
    output logic [CNT_WIDTH-1:0]  num_short_pkts
);

    tracker_state_e        state_q, state_d;
    logic [WORD_CNT_W-1:0] word_cnt_q, word_cnt_d;
    logic                  ipv4_q, ipv4_d;

    logic                  ctrl_zero;
    logic                  active;
    logic                  data_word;
    logic [WORD_CNT_W-1:0] word_idx;
    logic                  ip_gate;

    // Only the ethertype/version bits of the bus are inspected.
    logic unused_data;
    assign unused_data = ^{in_data[DATA_WIDTH-1:32], in_data[11:0]};

    assign ctrl_zero = (in_ctrl == '0);
    // Combinational outputs are suppressed while reset is held.
    assign active    = in_wr & ~reset;

    // Word 0 is recognised while still in MOD_HDRS; later header words (EOP included) come from IN_HDR.
    assign data_word = active & (((state_q == MOD_HDRS) & ctrl_zero) | (state_q == IN_HDR));
    assign word_idx  = (state_q == MOD_HDRS) ? WORD_CNT_W'(WORD_MAC_DA) : word_cnt_q;

`ifdef OP_LUT_IPV4_GATE_EN
    assign ip_gate = ipv4_q;
`else
    assign ip_gate = 1'b1;
`endif

    assign word_MAC_DA     = data_word & (word_idx == WORD_CNT_W'(WORD_MAC_DA));
    assign word_MAC_SA_ETH = data_word & (word_idx == WORD_CNT_W'(WORD_MAC_SA_ETH));
    assign word_IP_LEN_TTL = data_word & ip_gate & (word_idx == WORD_CNT_W'(WORD_IP_LEN_TTL));
    assign word_IP_SRC_DST = data_word & ip_gate & (word_idx == WORD_CNT_W'(WORD_IP_SRC_DST));
    assign word_IP_DST_LO  = data_word & ip_gate & (word_idx == WORD_CNT_W'(WORD_IP_DST_LO));

    assign eop       = active & ~ctrl_zero & (state_q != MOD_HDRS);
    // Short means the packet ended before the dest-IP low word was reached.
    assign short_pkt = eop & ip_gate & (state_q == IN_HDR) &
                       (word_cnt_q < WORD_CNT_W'(WORD_IP_DST_LO));

    assign pkt_is_ipv4 = ipv4_q;

    // Next-state: word position tracking and IPv4 flag capture.
    always_comb begin
        state_d    = state_q;
        word_cnt_d = word_cnt_q;
        ipv4_d     = ipv4_q;
        if (in_wr) begin
            unique case (state_q)
                MOD_HDRS: begin
                    if (ctrl_zero) begin
                        state_d    = IN_HDR;
                        word_cnt_d = WORD_CNT_W'(1);
                    end
                end
                IN_HDR: begin
                    if (ctrl_zero) begin
                        if (word_cnt_q != WORD_CNT_W'(WORD_CNT_SAT)) begin
                            word_cnt_d = word_cnt_q + WORD_CNT_W'(1);
                        end
                        if (word_cnt_q == WORD_CNT_W'(WORD_IP_DST_LO)) begin
                            state_d = PAYLOAD;
                        end
                    end else begin
                        state_d    = MOD_HDRS;
                        word_cnt_d = '0;
                    end
                end
                PAYLOAD: begin
                    if (!ctrl_zero) begin
                        state_d    = MOD_HDRS;
                        word_cnt_d = '0;
                    end
                end
                default: begin
                    state_d    = MOD_HDRS;
                    word_cnt_d = '0;
                end
            endcase
        end
        if (word_MAC_SA_ETH) begin
            ipv4_d = is_ipv4(in_data[31:16], in_data[15:12]);
        end
        if (eop) begin
            ipv4_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= MOD_HDRS;
            word_cnt_q <= '0;
            ipv4_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            word_cnt_q <= word_cnt_d;
            ipv4_q     <= ipv4_d;
        end
    end

    op_lut_stat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_pkt_cnt (
        .clk     (clk),
        .reset   (reset),
        .inc_i   (eop),
        .count_o (num_pkts)
    );

    op_lut_stat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_short_cnt (
        .clk     (clk),
        .reset   (reset),
        .inc_i   (short_pkt),
        .count_o (num_short_pkts)
    );

endmodule

// File: tb/tb_op_lut_hdr_word_tracker.sv
// Directed bench for the op-LUT header word tracker.
module tb_op_lut_hdr_word_tracker;

    logic        clk;
    logic        reset;
    logic [63:0] in_data;
    logic [7:0]  in_ctrl;
    logic        in_wr;
    logic        word_MAC_DA, word_MAC_SA_ETH, word_IP_LEN_TTL, word_IP_SRC_DST, word_IP_DST_LO;
    logic        pkt_is_ipv4, eop, short_pkt;
    logic [31:0] num_pkts, num_short_pkts;
    logic [4:0]  strb;

    int total = 0;
    int bad   = 0;

`ifdef OP_LUT_IPV4_GATE_EN
    localparam logic GATE = 1'b1;
`else
    localparam logic GATE = 1'b0;
`endif

    localparam logic [63:0] HDR   = 64'hFACE_0000_0000_0001;
    localparam logic [63:0] W0    = 64'h0011_2233_4455_6677;
    localparam logic [63:0] W1    = 64'h8899_AABB_0800_4500;
    localparam logic [63:0] W1ARP = 64'h8899_AABB_0806_0001;
    localparam logic [63:0] W2    = 64'h0028_1234_4000_4006;
    localparam logic [63:0] W3    = 64'hBEEF_C0A8_0001_0A00;
    localparam logic [63:0] W4    = 64'h0102_1111_2222_3333;
    localparam logic [63:0] W5    = 64'h5555_5555_5555_5555;
    localparam logic [63:0] W6    = 64'h6666_6666_6666_6666;
    localparam logic [63:0] W7    = 64'h7777_7777_0000_0000;

    op_lut_hdr_word_tracker dut (
        .clk             (clk),
        .reset           (reset),
        .in_data         (in_data),
        .in_ctrl         (in_ctrl),
        .in_wr           (in_wr),
        .word_MAC_DA     (word_MAC_DA),
        .word_MAC_SA_ETH (word_MAC_SA_ETH),
        .word_IP_LEN_TTL (word_IP_LEN_TTL),
        .word_IP_SRC_DST (word_IP_SRC_DST),
        .word_IP_DST_LO  (word_IP_DST_LO),
        .pkt_is_ipv4     (pkt_is_ipv4),
        .eop             (eop),
        .short_pkt       (short_pkt),
        .num_pkts        (num_pkts),
        .num_short_pkts  (num_short_pkts)
    );

    assign strb = {word_IP_DST_LO, word_IP_SRC_DST, word_IP_LEN_TTL, word_MAC_SA_ETH, word_MAC_DA};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one bus cycle at the falling edge, then check the combinational and registered outputs.
    task automatic step(input logic rst, input logic wr, input logic [7:0] ctrl, input logic [63:0] data,
                        input logic [4:0] es, input logic ee, input logic esh, input logic eip,
                        input string tag);
        @(negedge clk);
        reset   = rst;
        in_wr   = wr;
        in_ctrl = ctrl;
        in_data = data;
        #1;
        chk({tag, ".strb"},  64'(strb),        64'(es));
        chk({tag, ".eop"},   64'(eop),         64'(ee));
        chk({tag, ".short"}, 64'(short_pkt),   64'(esh));
        chk({tag, ".ipv4"},  64'(pkt_is_ipv4), 64'(eip));
    endtask

    task automatic counts(input string tag, input logic [31:0] ep, input logic [31:0] es);
        chk({tag, ".num_pkts"},       64'(num_pkts),       64'(ep));
        chk({tag, ".num_short_pkts"}, 64'(num_short_pkts), 64'(es));
    endtask

    // Complete 8-word IPv4 packet to 10.0.1.2 (header words excluded).
    task automatic send_ipv4(input string tag);
        step(0, 1, 8'h00, W0, 5'b00001, 0, 0, 0, {tag, ".w0"});
        step(0, 1, 8'h00, W1, 5'b00010, 0, 0, 0, {tag, ".w1"});
        step(0, 1, 8'h00, W2, 5'b00100, 0, 0, 1, {tag, ".w2"});
        step(0, 1, 8'h00, W3, 5'b01000, 0, 0, 1, {tag, ".w3"});
        chk({tag, ".dst_hi"}, word_IP_SRC_DST ? 64'(in_data[15:0]) : 64'hDEAD, 64'h0A00);
        step(0, 1, 8'h00, W4, 5'b10000, 0, 0, 1, {tag, ".w4"});
        chk({tag, ".dst_lo"}, word_IP_DST_LO ? 64'(in_data[63:48]) : 64'hDEAD, 64'h0102);
        step(0, 1, 8'h00, W5, 5'b00000, 0, 0, 1, {tag, ".w5"});
        step(0, 1, 8'h00, W6, 5'b00000, 0, 0, 1, {tag, ".w6"});
        step(0, 1, 8'h80, W7, 5'b00000, 1, 0, 1, {tag, ".w7"});
    endtask

    initial begin
        reset   = 1'b1;
        in_wr   = 1'b0;
        in_ctrl = 8'h00;
        in_data = 64'h0;

        // Reset state
        step(1, 0, 8'h00, 64'h0, 5'b0, 0, 0, 0, "rst0");
        step(1, 0, 8'h00, 64'h0, 5'b0, 0, 0, 0, "rst1");
        counts("rst", 0, 0);
        step(0, 0, 8'h00, 64'h0, 5'b0, 0, 0, 0, "idle0");

        // Two module headers then an 8-word IPv4 packet
        step(0, 1, 8'hFF, HDR, 5'b0, 0, 0, 0, "p1.h0");
        step(0, 1, 8'hFF, HDR, 5'b0, 0, 0, 0, "p1.h1");
        send_ipv4("p1");
        step(0, 0, 8'h00, 64'h0, 5'b0, 0, 0, 0, "p1.idle");
        counts("p1", 1, 0);

        // Same packet with in_wr gaps between words 2/3/4
        step(0, 1, 8'hFF, HDR, 5'b0, 0, 0, 0, "p2.h0");
        step(0, 1, 8'h00, W0, 5'b00001, 0, 0, 0, "p2.w0");
        step(0, 1, 8'h00, W1, 5'b00010, 0, 0, 0, "p2.w1");
        step(0, 1, 8'h00, W2, 5'b00100, 0, 0, 1, "p2.w2");
        step(0, 0, 8'h00, W3, 5'b00000, 0, 0, 1, "p2.gap0");
        step(0, 1, 8'h00, W3, 5'b01000, 0, 0, 1, "p2.w3");
        chk("p2.dst_hi", word_IP_SRC_DST ? 64'(in_data[15:0]) : 64'hDEAD, 64'h0A00);
        step(0, 0, 8'h00, W4, 5'b00000, 0, 0, 1, "p2.gap1");
        step(0, 0, 8'h00, W4, 5'b00000, 0, 0, 1, "p2.gap2");
        step(0, 1, 8'h00, W4, 5'b10000, 0, 0, 1, "p2.w4");
        chk("p2.dst_lo", word_IP_DST_LO ? 64'(in_data[63:48]) : 64'hDEAD, 64'h0102);
        step(0, 0, 8'h00, W5, 5'b00000, 0, 0, 1, "p2.gap3");
        step(0, 1, 8'h00, W5, 5'b00000, 0, 0, 1, "p2.w5");
        step(0, 1, 8'h80, W7, 5'b00000, 1, 0, 1, "p2.w6");
        step(0, 0, 8'h00, 64'h0, 5'b0, 0, 0, 0, "p2.idle");
        counts("p2", 2, 0);

        // Short packet: EOP on word 2
        step(0, 1, 8'hFF, HDR, 5'b0, 0, 0, 0, "p3.h0");
        step(0, 1, 8'h00, W0, 5'b00001, 0, 0, 0, "p3.w0");
        step(0, 1, 8'h00, W1, 5'b00010, 0, 0, 0, "p3.w1");
        step(0, 1, 8'hC0, W2, 5'b00100, 1, 1, 1, "p3.w2");
        step(0, 0, 8'h00, 64'h0, 5'b0, 0, 0, 0, "p3.idle");
        counts("p3", 3, 1);

        // ARP packet: IP-word strobes depend on the gating option
        step(0, 1, 8'hFF, HDR, 5'b0, 0, 0, 0, "p4.h0");
        step(0, 1, 8'h00, W0, 5'b00001, 0, 0, 0, "p4.w0");
        step(0, 1, 8'h00, W1ARP, 5'b00010, 0, 0, 0, "p4.w1");
        step(0, 1, 8'h00, W2, GATE ? 5'b00000 : 5'b00100, 0, 0, 0, "p4.w2");
        step(0, 1, 8'h00, W3, GATE ? 5'b00000 : 5'b01000, 0, 0, 0, "p4.w3");
        step(0, 1, 8'h00, W4, GATE ? 5'b00000 : 5'b10000, 0, 0, 0, "p4.w4");
        step(0, 1, 8'h80, W5, 5'b00000, 1, 0, 0, "p4.w5");
        step(0, 0, 8'h00, 64'h0, 5'b0, 0, 0, 0, "p4.idle");
        counts("p4", 4, 1);

        // EOP exactly on word 4 is not short
        step(0, 1, 8'hFF, HDR, 5'b0, 0, 0, 0, "p5.h0");
        step(0, 1, 8'h00, W0, 5'b00001, 0, 0, 0, "p5.w0");
        step(0, 1, 8'h00, W1, 5'b00010, 0, 0, 0, "p5.w1");
        step(0, 1, 8'h00, W2, 5'b00100, 0, 0, 1, "p5.w2");
        step(0, 1, 8'h00, W3, 5'b01000, 0, 0, 1, "p5.w3");
        step(0, 1, 8'h80, W4, 5'b10000, 1, 0, 1, "p5.w4");
        step(0, 0, 8'h00, 64'h0, 5'b0, 0, 0, 0, "p5.idle");
        counts("p5", 5, 1);

        // Reset held from word 2 through word 6; the EOP tail is taken as a module header
        step(0, 1, 8'hFF, HDR, 5'b0, 0, 0, 0, "p6.h0");
        step(0, 1, 8'h00, W0, 5'b00001, 0, 0, 0, "p6.w0");
        step(0, 1, 8'h00, W1, 5'b00010, 0, 0, 0, "p6.w1");
        step(1, 1, 8'h00, W2, 5'b00000, 0, 0, 1, "p6.w2r");
        step(1, 1, 8'h00, W3, 5'b00000, 0, 0, 0, "p6.w3r");
        step(1, 1, 8'h00, W4, 5'b00000, 0, 0, 0, "p6.w4r");
        step(1, 1, 8'h00, W5, 5'b00000, 0, 0, 0, "p6.w5r");
        step(1, 1, 8'h00, W6, 5'b00000, 0, 0, 0, "p6.w6r");
        counts("p6.rst", 0, 0);
        step(0, 1, 8'h80, W7, 5'b00000, 0, 0, 0, "p6.tail");
        step(0, 1, 8'hFF, HDR, 5'b0, 0, 0, 0, "p7.h0");
        send_ipv4("p7");

        // Back-to-back: module header on the cycle right after EOP
        step(0, 1, 8'hFF, HDR, 5'b0, 0, 0, 0, "p8.h0");
        send_ipv4("p8");
        step(0, 0, 8'h00, 64'h0, 5'b0, 0, 0, 0, "p8.idle");
        counts("p8", 2, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
